// File: rtl/seg_msg_pkg.sv
// Shared types and constants for the scrolling seven-segment message controller.
package seg_msg_pkg;

    localparam int DIGIT_W    = 8;
    localparam int NUM_DIGITS = 8;

    localparam logic [DIGIT_W-1:0] BLANK_CODE_DEF = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        CLEAR = 2'd3
    } seg_state_e;

    // Plain vectors of the enum values so the state register can stay a logic vector.
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_HOLD  = HOLD;
    localparam logic [1:0] ST_CLEAR = CLEAR;

endpackage

// File: rtl/seg_char_fifo.sv
// Small synchronous character FIFO with show-ahead head output and a flush input.
module seg_char_fifo
    import seg_msg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_fast,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [DIGIT_W-1:0]     din,
    output logic [DIGIT_W-1:0]     dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DIGIT_W-1:0] mem_reg [DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [AW:0]        count_reg;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count_reg == (AW + 1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign dout    = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk_fast) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push_ok && !pop_ok)      count_reg <= count_reg + 1'b1;
            else if (pop_ok && !push_ok) count_reg <= count_reg - 1'b1;
        end
    end

endmodule

// File: rtl/seg_msg_ctrl.sv
// Scroll controller: buffers segment codes and shifts one into the 8-digit display word per tick.
module seg_msg_ctrl
    import seg_msg_pkg::*;
#(
    parameter int                 TICK_DIV   = 50_000_000,
    parameter int                 BLINK_DIV  = 25_000_000,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [DIGIT_W-1:0] BLANK_CODE = BLANK_CODE_DEF
) (
    input  logic                        clk_fast,
    input  logic                        rst,
    input  logic                        chr_valid,
    input  logic [DIGIT_W-1:0]          chr_code,
    output logic                        chr_ready,
    input  logic                        clr,
    input  logic                        blink_en,
    output logic [63:0]                 disp_word,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [1:0]                    state_reg, state_next;
    logic [TW-1:0]                 tick_reg, tick_next;
    logic [BW-1:0]                 blink_cnt_reg;
    logic                          blink_phase_reg;
    logic [DIGIT_W*NUM_DIGITS-1:0] buf_reg;

    logic               fifo_full, fifo_empty;
    logic [DIGIT_W-1:0] fifo_dout;
    logic               push, do_shift, flush, tick_done, blink_done, cursor_off;

    // Ready never looks at chr_valid, so the producer sees no combinational loop.
    assign chr_ready  = !fifo_full && !clr && (state_reg != ST_CLEAR);
    assign push       = chr_valid && chr_ready;
    assign do_shift   = (state_reg == ST_SHIFT) && !clr;
    assign flush      = (state_reg == ST_CLEAR);
    assign tick_done  = (tick_reg == TW'(TICK_DIV - 1));
    assign blink_done = (blink_cnt_reg == BW'(BLINK_DIV - 1));
    assign busy       = (state_reg != ST_IDLE) || !fifo_empty;
    assign cursor_off = blink_en && blink_phase_reg && (state_reg == ST_IDLE);

    seg_char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_fast (clk_fast),
        .rst      (rst),
        .push     (push),
        .pop      (do_shift),
        .flush    (flush),
        .din      (chr_code),
        .dout     (fifo_dout),
        .count    (fifo_cnt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_next = state_reg;
        tick_next  = '0;
        if (clr) begin
            state_next = ST_CLEAR;
        end else begin
            case (state_reg)
                ST_IDLE:  if (!fifo_empty) state_next = ST_SHIFT;
                ST_SHIFT: state_next = ST_HOLD;
                ST_HOLD: begin
                    if (tick_done) state_next = fifo_empty ? ST_IDLE : ST_SHIFT;
                    else           tick_next  = tick_reg + 1'b1;
                end
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            tick_reg        <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            buf_reg         <= {NUM_DIGITS{BLANK_CODE}};
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            if (blink_done) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= !blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
            if (flush)         buf_reg <= {NUM_DIGITS{BLANK_CODE}};
            else if (do_shift) buf_reg <= {buf_reg[DIGIT_W*(NUM_DIGITS-1)-1:0], fifo_dout};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_cursor
                assign disp_word[DIGIT_W-1:0] = cursor_off ? BLANK_CODE : buf_reg[DIGIT_W-1:0];
            end else begin : g_plain
                assign disp_word[gi*DIGIT_W +: DIGIT_W] = buf_reg[gi*DIGIT_W +: DIGIT_W];
            end
        end
    endgenerate

endmodule

// File: tb/tb_seg_msg_ctrl.sv
// Directed and random checks of seg_msg_ctrl against a queue-based behavioural model.
module tb_seg_msg_ctrl;

    localparam int          TICK_DIV   = 4;
    localparam int          BLINK_DIV  = 3;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [7:0]  BLANK      = 8'h00;

    logic        clk_fast = 1'b0;
    logic        rst = 1'b1;
    logic        chr_valid = 1'b0;
    logic [7:0]  chr_code = 8'h00;
    logic        chr_ready;
    logic        clr = 1'b0;
    logic        blink_en = 1'b0;
    logic [63:0] disp_word;
    logic        busy;
    logic [2:0]  fifo_cnt;

    seg_msg_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .BLINK_DIV  (BLINK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BLANK_CODE (BLANK)
    ) dut (
        .clk_fast  (clk_fast),
        .rst       (rst),
        .chr_valid (chr_valid),
        .chr_code  (chr_code),
        .chr_ready (chr_ready),
        .clr       (clr),
        .blink_en  (blink_en),
        .disp_word (disp_word),
        .busy      (busy),
        .fifo_cnt  (fifo_cnt)
    );

    always #5 clk_fast = ~clk_fast;

    int n_checks = 0;
    int n_errors = 0;

    // Model: pending characters, the 8 visible digits (index 0 = rightmost),
    // and where we are in the scroll cycle expressed as "shift due" / "hold cycles left".
    logic [7:0] mq[$];
    logic [7:0] mdisp[8];
    bit         m_shift_due;
    int         m_hold_left;
    bit         m_clearing;
    int         m_cycles;
    bit         acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) mdisp[i] = BLANK;
        m_shift_due = 1'b0;
        m_hold_left = 0;
        m_clearing  = 1'b0;
        m_cycles    = 0;
    endtask

    function automatic bit model_idle();
        return !m_shift_due && (m_hold_left == 0) && !m_clearing;
    endfunction

    function automatic logic [63:0] model_word(input logic b);
        logic [63:0] e;
        for (int i = 0; i < 8; i++) e[i*8 +: 8] = mdisp[i];
        if (b && ((m_cycles / BLINK_DIV) % 2 == 1) && model_idle()) e[7:0] = BLANK;
        return e;
    endfunction

    // One clock cycle: drive inputs, check ready, advance model across the edge, check outputs.
    task automatic step(input logic v, input logic [7:0] code, input logic c, input logic b,
                        output bit accepted);
        bit m_ready;
        bit m_push;
        bit nonempty;
        chr_valid = v;
        chr_code  = code;
        clr       = c;
        blink_en  = b;
        #1;
        m_ready = (mq.size() < FIFO_DEPTH) && !c && !m_clearing;
        check("chr_ready", 64'(chr_ready), 64'(m_ready));
        m_push   = v && m_ready;
        accepted = m_push;
        @(posedge clk_fast);
        nonempty = (mq.size() > 0);
        if (m_clearing) begin
            for (int i = 0; i < 8; i++) mdisp[i] = BLANK;
            mq.delete();
            m_clearing = c;
        end else if (c) begin
            m_clearing  = 1'b1;
            m_shift_due = 1'b0;
            m_hold_left = 0;
        end else if (m_shift_due) begin
            for (int i = 7; i > 0; i--) mdisp[i] = mdisp[i-1];
            mdisp[0]    = mq.pop_front();
            m_shift_due = 1'b0;
            m_hold_left = TICK_DIV;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0 && nonempty) m_shift_due = 1'b1;
        end else if (nonempty) begin
            m_shift_due = 1'b1;
        end
        if (m_push) mq.push_back(code);
        m_cycles++;
        #1;
        check("disp_word", disp_word, model_word(b));
        check("fifo_cnt", 64'(fifo_cnt), 64'(mq.size()));
        check("busy", 64'(busy), 64'(!model_idle() || mq.size() > 0));
    endtask

    task automatic idle_steps(input int n, input logic b);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, b, acc);
    endtask

    task automatic push_char(input logic [7:0] code, input logic b);
        int tries = 0;
        do begin
            step(1'b1, code, 1'b0, b, acc);
            tries++;
        end while (!acc && tries < 40);
        check("push_accepted", 64'(acc), 64'(1));
    endtask

    task automatic wait_idle(input logic b);
        int t = 0;
        while (busy && t < 100) begin
            step(1'b0, 8'h00, 1'b0, b, acc);
            t++;
        end
        check("idle_reached", 64'(busy), 64'(0));
    endtask

    task automatic clear_pulse();
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst       = 1'b1;
        chr_valid = 1'b0;
        clr       = 1'b0;
        blink_en  = 1'b0;
        #1;
        check("rst_disp", disp_word, 64'h0);
        check("rst_cnt", 64'(fifo_cnt), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        model_reset();
        @(posedge clk_fast);
        @(posedge clk_fast);
        #3;
        rst = 1'b0;
        #1;
        check("rst_ready", 64'(chr_ready), 64'(1));
    endtask

    logic b_rand;

    initial begin
        model_reset();
        @(posedge clk_fast);
        #1;
        do_reset();

        // Single character from idle: visible two edges after acceptance.
        step(1'b1, 8'h3F, 1'b0, 1'b0, acc);
        check("t2_accept", 64'(acc), 64'(1));
        idle_steps(2, 1'b0);
        check("t2_disp", disp_word, 64'h3F);
        check("t2_busy_hold", 64'(busy), 64'(1));
        idle_steps(3, 1'b0);
        check("t2_busy_end_hold", 64'(busy), 64'(1));
        idle_steps(1, 1'b0);
        check("t2_busy_idle", 64'(busy), 64'(0));

        // Fill the FIFO during HOLD and stall the sixth character.
        clear_pulse();
        push_char(8'h01, 1'b0);
        idle_steps(2, 1'b0);
        for (int k = 2; k <= 5; k++) push_char(8'(k), 1'b0);
        check("t3_full_cnt", 64'(fifo_cnt), 64'(4));
        step(1'b1, 8'h06, 1'b0, 1'b0, acc);
        check("t3_stall", 64'(acc), 64'(0));
        push_char(8'h06, 1'b0);
        wait_idle(1'b0);
        check("t3_final", disp_word, 64'h0000010203040506);

        // Nine characters: oldest scroll off the left.
        for (int k = 1; k <= 9; k++) push_char(8'(k), 1'b0);
        wait_idle(1'b0);
        check("t4_final", disp_word, 64'h0203040506070809);

        // Clear during HOLD with two queued characters and a character on offer.
        push_char(8'hA1, 1'b0);
        push_char(8'hA2, 1'b0);
        push_char(8'hA3, 1'b0);
        check("t5_cnt2", 64'(fifo_cnt), 64'(2));
        step(1'b1, 8'h77, 1'b1, 1'b0, acc);
        check("t5_clr_reject", 64'(acc), 64'(0));
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        check("t5_disp", disp_word, 64'h0);
        check("t5_cnt", 64'(fifo_cnt), 64'(0));
        check("t5_busy", 64'(busy), 64'(0));
        idle_steps(4, 1'b0);

        // Cursor blink in idle, then unmasked once scrolling starts.
        push_char(8'h3F, 1'b0);
        wait_idle(1'b0);
        idle_steps(12, 1'b1);
        check("t6_upper", 64'(disp_word[63:8]), 64'h0);
        push_char(8'h5A, 1'b1);
        idle_steps(2, 1'b1);
        check("t6_unmask", 64'(disp_word[7:0]), 64'h5A);
        wait_idle(1'b1);

        // Random traffic with occasional clears and blink toggling.
        b_rand = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) b_rand = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 39) == 0), b_rand, acc);
        end

        // Reset in the middle of activity.
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1, acc);
        do_reset();
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 29) == 0), 1'b1, acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
